// File: rtl/ysyx_22050612_wb_arbiter.sv
// Writeback arbiter plus busy scoreboard for the integer register file write port.
// Define YSYX_22050612_WB_RR_EN for round-robin grant; otherwise fixed priority, lowest index first.
module ysyx_22050612_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NREQ       = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic                       rf_wen,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    input  logic                       sb_set,
    input  logic [ADDR_WIDTH-1:0]      sb_set_addr,
    input  logic [ADDR_WIDTH-1:0]      rs1,
    input  logic [ADDR_WIDTH-1:0]      rs2,
    output logic                       rs1_busy,
    output logic                       rs2_busy
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int IW   = $clog2(NREQ);

    logic                  gnt_vld;
    logic [IW-1:0]         gnt_idx;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_data;

    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]       sb_q, sb_d;

`ifdef YSYX_22050612_WB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
`endif

    // Scan requesters in priority order; the first valid one wins.
    always_comb begin
        int            pos;
        logic [IW-1:0] idx;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef YSYX_22050612_WB_RR_EN
            pos = int'(ptr_q) + k;
            if (pos >= NREQ) pos = pos - NREQ;
`else
            pos = k;
`endif
            idx = IW'(pos);
            if (!gnt_vld && req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
        if (gnt_vld) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        gnt_addr = '0;
        gnt_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IW'(k)) begin
                gnt_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Writes to x0 still complete the handshake but never reach the file.
    always_comb begin
        rf_wen_d   = gnt_vld && (gnt_addr != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (rf_wen_d) begin
            rf_waddr_d = gnt_addr;
            rf_wdata_d = gnt_data;
        end
    end

    // Clear retires on the same edge the file captures; a fresh set wins over it.
    always_comb begin
        sb_d = sb_q;
        if (rf_wen_q) sb_d[rf_waddr_q] = 1'b0;
        if (sb_set && sb_set_addr != '0) sb_d[sb_set_addr] = 1'b1;
        sb_d[0] = 1'b0;
    end

`ifdef YSYX_22050612_WB_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            sb_q       <= '0;
`ifdef YSYX_22050612_WB_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            sb_q       <= sb_d;
`ifdef YSYX_22050612_WB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign rs1_busy = sb_q[rs1];
    assign rs2_busy = sb_q[rs2];

endmodule

// File: tb/tb_ysyx_22050612_wb_arbiter.sv
// Randomized bench for the writeback arbiter, checked against a behavioural model.
module tb_ysyx_22050612_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic                 rf_wen;
    logic [AW-1:0]        rf_waddr;
    logic [DW-1:0]        rf_wdata;
    logic                 sb_set = 1'b0;
    logic [AW-1:0]        sb_set_addr = '0;
    logic [AW-1:0]        rs1 = '0, rs2 = '0;
    logic                 rs1_busy, rs2_busy;

    ysyx_22050612_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: pending write visible in the output register, busy set, priority pointer.
    int            m_ptr = 0;
    bit            m_busy[32];
    bit            m_wen = 0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            m_gnt;
    logic [NREQ-1:0] obs_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        int j;
        for (int k = 0; k < NREQ; k++) begin
`ifdef YSYX_22050612_WB_RR_EN
            j = (m_ptr + k) % NREQ;
`else
            j = k;
`endif
            if (req_valid[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endfunction

    function automatic void model_edge(input int g);
        logic [AW-1:0] a;
        if (m_wen) m_busy[m_waddr] = 0;
        if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] = 1;
        if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            m_wen = (a != 0);
            if (a != 0) begin
                m_waddr = a;
                m_wdata = req_data[g*DW +: DW];
            end
            m_ptr = (g + 1) % NREQ;
        end else begin
            m_wen = 0;
        end
    endfunction

    // Inputs are already driven just after a falling edge.
    task automatic tick();
        #1;
        m_gnt = model_grant();
        obs_ready = req_ready;
        check("req_ready", req_ready, (m_gnt < 0) ? 0 : (1 << m_gnt));
        @(posedge clk);
        if (rst_n) model_edge(m_gnt);
        @(negedge clk);
        check("rf_wen", rf_wen, m_wen);
        if (m_wen) begin
            check("rf_waddr", rf_waddr, m_waddr);
            check("rf_wdata", rf_wdata, m_wdata);
        end
        check("rs1_busy", rs1_busy, m_busy[rs1]);
        check("rs2_busy", rs2_busy, m_busy[rs2]);
    endtask

    task automatic idle();
        req_valid = '0; sb_set = 1'b0;
    endtask

    task automatic rand_inputs();
        req_valid = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
            req_data[i*DW +: DW] = {$urandom, $urandom};
        end
        sb_set      = ($urandom_range(0, 2) == 0);
        sb_set_addr = AW'($urandom_range(0, 31));
        rs1 = ($urandom_range(0, 3) == 0) ? m_waddr : AW'($urandom_range(0, 31));
        rs2 = AW'($urandom_range(0, 31));
    endtask

    task automatic put(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        int pulses;
        int g;
        model_reset();
        // Reset held with random inputs: ready still follows valid with pointer at 0.
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            rand_inputs();
            tick();
            check("rst_waddr", rf_waddr, 0);
            check("rst_wdata", rf_wdata, 0);
        end
        idle();
        rst_n = 1'b1;

        // First write from the ALU.
        req_valid = 3'b010; put(1, 5'd5, 64'h1234);
        tick();
        check("first_wen", rf_wen, 1);
        check("first_waddr", rf_waddr, 5);
        check("first_wdata", rf_wdata, 64'h1234);

        // Scoreboard set then retire through the ALU.
        idle(); sb_set = 1'b1; sb_set_addr = 5'd7; rs1 = 5'd7;
        tick();
        check("sb7_set", rs1_busy, 1);
        idle(); req_valid = 3'b010; put(1, 5'd7, 64'hABCD);
        tick();
        check("sb7_inflight", rs1_busy, 1);
        idle();
        tick();
        check("sb7_clear", rs1_busy, 0);

        // Set and clear of index 9 on the same edge.
        idle(); sb_set = 1'b1; sb_set_addr = 5'd9; rs2 = 5'd9;
        tick();
        idle(); req_valid = 3'b010; put(1, 5'd9, 64'h99);
        tick();
        check("wen9", rf_wen, 1);
        idle(); sb_set = 1'b1; sb_set_addr = 5'd9;
        tick();
        check("set_wins", rs2_busy, 1);

        // Writes and busy marks to x0.
        idle(); req_valid = 3'b001; put(0, 5'd0, 64'hFFFF);
        tick();
        check("x0_ready", obs_ready, 3'b001);
        check("x0_wen", rf_wen, 0);
        idle(); sb_set = 1'b1; sb_set_addr = 5'd0; rs2 = 5'd0;
        tick();
        check("x0_busy", rs2_busy, 0);

        idle();
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            tick();
        end

        // Mid-operation reset with busy bits set and a write in flight.
        idle();
        for (int i = 3; i < 7; i++) begin
            sb_set = 1'b1; sb_set_addr = AW'(i);
            tick();
        end
        idle(); req_valid = 3'b100; put(2, 5'd10, 64'h5A5A);
        tick();
        check("pre_rst_wen", rf_wen, 1);
        idle(); rs1 = 5'd3; rs2 = 5'd6;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wen", rf_wen, 0);
        check("mid_rst_waddr", rf_waddr, 0);
        check("mid_rst_wdata", rf_wdata, 0);
        check("mid_rst_busy1", rs1_busy, 0);
        check("mid_rst_busy2", rs2_busy, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Contention on all requesters for six cycles.
        req_valid = 3'b111;
        put(0, 5'd1, 64'h10); put(1, 5'd2, 64'h20); put(2, 5'd3, 64'h30);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            g = -1;
            for (int i = 0; i < NREQ; i++) if (obs_ready[i]) g = i;
`ifdef YSYX_22050612_WB_RR_EN
            check("contend_gnt", g, c % NREQ);
`else
            check("contend_gnt", g, 0);
`endif
            if (rf_wen) pulses++;
        end
        check("contend_pulses", pulses, 6);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ysyx_22050612_wb_arbiter.md
# ysyx_22050612_wb_arbiter

Writeback controller in front of the integer register file's single write port. Arbitrates up to NREQ writeback requesters (ALU, LSU, CSR unit) over valid/ready handshakes and drives one registered write per cycle into the register file. Keeps a per-register busy scoreboard that the issue stage sets and this block clears, so decode can stall on pending destination registers.

## Interface
- ADDR_WIDTH, 5, register index width; the file has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 64, write data width.
- NREQ, 3, number of writeback requesters, from 2 to 8; index 0 is the LSU, 1 the ALU, 2 the CSR unit.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  requester i has a write pending.
- req_ready  output  NREQ  requester i is granted this cycle; combinational.
- req_addr  input  NREQ*ADDR_WIDTH  destination index; slice i is [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  input  NREQ*DATA_WIDTH  write data; slice i is [i*DATA_WIDTH +: DATA_WIDTH].
- rf_wen  output  1  register-file write enable; registered.
- rf_waddr  output  ADDR_WIDTH  register-file write index; registered.
- rf_wdata  output  DATA_WIDTH  register-file write data; registered.
- sb_set  input  1  issue stage marks a destination register busy.
- sb_set_addr  input  ADDR_WIDTH  index to mark busy.
- rs1, rs2  input  ADDR_WIDTH  source indices to query.
- rs1_busy, rs2_busy  output  1  queried register has a write outstanding; combinational.

## Operation
- Grant:
  - At most one req_ready bit is high per cycle, and only for a requester with req_valid=1.
  - The output register always accepts, so a grant is issued every cycle any request is valid.
  - Handshake completes on a rising edge where req_valid[i] and req_ready[i] are both 1.
  - req_ready never depends on any requester's ready.
- Output stage:
  - On a handshake, rf_waddr and rf_wdata load the granted slices.
  - rf_wen loads 1, except when the granted address is 0, where it loads 0.
  - rf_wen loads 0 when there is no handshake.
  - rf_waddr and rf_wdata hold their values when rf_wen loads 0.
- Scoreboard (2**ADDR_WIDTH bits):
  - Bit k is set on an edge with sb_set=1 and sb_set_addr=k, k≠0.
  - Bit k is cleared on an edge with rf_wen=1 and rf_waddr=k, the same edge the register file captures the data.
  - If set and clear hit the same index on the same edge, set wins (a new producer was issued).
  - Bit 0 is constant 0; sb_set to index 0 is ignored.
  - rsN_busy = scoreboard[rsN], from the current register state with no bypass of same-cycle set or clear.
- Reset (asynchronous, rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All scoreboard bits 0.
  - Round-robin pointer 0.
  - req_ready follows req_valid combinationally even while in reset, but no state changes until rst_n deasserts.
  - An rf_wen pulse in flight when reset asserts is dropped.

## Timing
- Handshake at edge N: rf_wen=1 during cycle N+1; the register file holds the data after edge N+1; the busy bit is clear after edge N+1.
- Throughput: one write per cycle, with back-to-back grants allowed.
- A reader querying the index in cycle N+1 still sees busy=1 and stale data; from cycle N+2 it sees busy=0 and the new value.
- The scoreboard does not track multiple outstanding writes to the same index. The issue stage must not set an index that is already busy (WAW stall upstream).

## Configuration
- YSYX_22050612_WB_RR_EN defined: round-robin arbitration.
  - Pointer p starts at 0; priority order is p, p+1, … mod NREQ.
  - After a handshake by requester i, p becomes (i+1) mod NREQ.
  - p holds when there is no handshake.
- YSYX_22050612_WB_RR_EN undefined: fixed priority, lowest index wins (the LSU always first). No pointer register exists.

## Test plan
- Reset: hold rst_n=0 with random inputs -> rf_wen=0, rf_waddr=0, rf_wdata=0, rs1_busy=rs2_busy=0. Deassert, then req_valid=3'b010, addr 5, data 0x1234 -> rf_wen=1, rf_waddr=5, rf_wdata=0x1234 one cycle later.
- Contention with RR enabled: req_valid=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2 and six rf_wen pulses. With RR disabled -> requester 0 granted on all 6 cycles.
- Scoreboard: sb_set to index 7 at edge 1 -> rs1=7 shows busy from cycle 2. ALU writes index 7 with handshake at edge 4 -> busy still 1 in cycle 5, 0 from cycle 6.
- Simultaneous set and clear: rf_wen=1 to index 9 on the same edge as sb_set to index 9 -> bit 9 remains 1.
- x0 handling: handshake with addr 0, data 0xFFFF -> req_ready=1, rf_wen stays 0. sb_set to index 0 -> rs2=0 reads busy=0.
- Mid-operation reset: assert rst_n low while rf_wen=1 and 4 scoreboard bits are set -> outputs 0 immediately and all busy bits 0. With RR enabled, after release req_valid=3'b111 -> first grant goes to requester 0.
